// File: rtl/color_seq_pkg.sv
// ---------------------------------------------------------------------------
// color_seq_pkg : state encoding and color constants for color_seq (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package color_seq_pkg;

  localparam int COLOR_W    = 2;
  localparam int NUM_COLORS = 4;
  localparam int MAX_COLOR  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    BACKTRACK = 3'd2,
    DONE      = 3'd3,
    FAIL      = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/color_seq.sv
// ---------------------------------------------------------------------------
// color_seq : backtracking four-color sequencer, optional COLOR_SEQ_CYCLE_CNT_EN
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module color_seq
  import color_seq_pkg::*;
#(
  parameter int N_REGIONS = 12,
  parameter int RIDX_W    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [N_REGIONS*N_REGIONS-1:0] adj,
  output logic [2*N_REGIONS-1:0]         colors,
  output logic [RIDX_W-1:0]              cur_region,
  output logic                           busy,
  output logic                           done,
  output logic                           fail
`ifdef COLOR_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                    cycle_cnt
`endif
);

  localparam logic [RIDX_W-1:0]  LAST_REGION = RIDX_W'(N_REGIONS - 1);
  localparam logic [COLOR_W-1:0] TOP_COLOR   = COLOR_W'(MAX_COLOR);

  state_t              state, state_n;
  logic [RIDX_W-1:0]   i, i_n, j, j_n, i_dec;
  logic [COLOR_W-1:0]  c, c_n, prev_color;
  logic [COLOR_W-1:0]  cmem [N_REGIONS];
  logic [N_REGIONS-1:0] adj_row [N_REGIONS];
  logic                conflict, wr_en, start_ok;

  generate
    for (genvar k = 0; k < N_REGIONS; k++) begin : g_unpack
      assign adj_row[k]            = adj[k*N_REGIONS +: N_REGIONS];
      assign colors[2*k +: COLOR_W] = cmem[k];
    end
  endgenerate

  assign cur_region = i;
  assign i_dec      = i - 1'b1;
  assign prev_color = cmem[i_dec];
  assign conflict   = adj_row[i][j] && (cmem[j] == c);
  assign start_ok   = start && (state == IDLE || state == DONE || state == FAIL);

  always_comb begin
    state_n = state;
    i_n     = i;
    c_n     = c;
    j_n     = j;
    wr_en   = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n = CHECK;
          i_n     = '0;
          c_n     = '0;
          j_n     = '0;
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = IDLE;
        end else if (j < i) begin
          if (conflict) begin
            if (c != TOP_COLOR) begin
              c_n = c + 1'b1;
              j_n = '0;
            end else begin
              state_n = BACKTRACK;
            end
          end else begin
            j_n = j + 1'b1;
          end
        end else begin
          wr_en = 1'b1;
          if (i == LAST_REGION) begin
            state_n = DONE;
          end else begin
            i_n = i + 1'b1;
            c_n = '0;
            j_n = '0;
          end
        end
      end
      BACKTRACK: begin
        if (abort) begin
          state_n = IDLE;
        end else if (i == '0) begin
          state_n = FAIL;
        end else begin
          // Resume the previous region from its committed color.
          i_n = i_dec;
          if (prev_color == TOP_COLOR) begin
            c_n = prev_color;
          end else begin
            c_n     = prev_color + 1'b1;
            j_n     = '0;
            state_n = CHECK;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      c     <= '0;
      j     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      i     <= i_n;
      c     <= c_n;
      j     <= j_n;
      busy  <= (state_n == CHECK) || (state_n == BACKTRACK);
      done  <= (state_n == DONE);
      fail  <= (state_n == FAIL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REGIONS; k++) cmem[k] <= '0;
    end else if (wr_en) begin
      cmem[i] <= c;
    end
  end

`ifdef COLOR_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
    end else if ((state == CHECK || state == BACKTRACK) && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_color_seq.sv
// ---------------------------------------------------------------------------
// tb_color_seq : scoreboard bench for color_seq (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_color_seq;

  localparam int N = 12;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [N*N-1:0]   adj;
  logic [2*N-1:0]   colors;
  logic [3:0]       cur_region;
  logic             busy, done, fail;
`ifdef COLOR_SEQ_CYCLE_CNT_EN
  logic [31:0]      cycle_cnt;
`endif

  color_seq #(.N_REGIONS(N), .RIDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .adj        (adj),
    .colors     (colors),
    .cur_region (cur_region),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
`ifdef COLOR_SEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] colors;
    logic           chk_colors;
    logic           done;
    logic           fail;
    int             cycles;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N*N-1:0] add_edge(input logic [N*N-1:0] a, input int x, input int y);
    logic [N*N-1:0] r;
    r = a;
    r[x*N+y] = 1'b1;
    r[y*N+x] = 1'b1;
    return r;
  endfunction

  // mid_start > 0 pulses start during that busy cycle, which must be ignored.
  task automatic run_search(input logic [N*N-1:0] a, input exp_t e, input int mid_start);
    exp_t ex;
    int   n;
    @(negedge clk);
    adj   = a;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {63'd0, busy}, 64'd1);
    check("flags_clear", {62'd0, done, fail}, 64'd0);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      if (n == mid_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (n >= 5000) check("timeout", 64'd1, 64'd0);
    ex = sb.pop_front();
    if (ex.chk_colors) check("colors", {40'd0, colors}, {40'd0, ex.colors});
    check("done", {63'd0, done}, {63'd0, ex.done});
    check("fail", {63'd0, fail}, {63'd0, ex.fail});
    check("busy_low", {63'd0, busy}, 64'd0);
    if (ex.cycles >= 0) begin
      check("busy_cycles", 64'(n), 64'(ex.cycles));
`ifdef COLOR_SEQ_CYCLE_CNT_EN
      check("cycle_cnt", {32'd0, cycle_cnt}, 64'(ex.cycles));
`endif
    end
  endtask

  logic [N*N-1:0] chain, k4, k5;
  exp_t           e;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    adj   = '0;
    chain = '0;
    k4    = '0;
    k5    = '0;
    for (int k = 1; k < N; k++) chain = add_edge(chain, k, k - 1);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < x; y++) k4 = add_edge(k4, x, y);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < x; y++) k5 = add_edge(k5, x, y);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_colors", {40'd0, colors}, 64'd0);
    check("rst_cur", {60'd0, cur_region}, 64'd0);
    check("rst_flags", {61'd0, busy, done, fail}, 64'd0);

    // Empty graph: every region takes color 0, 1+2+...+12 = 78 cycles.
    e = '{colors: '0, chk_colors: 1'b1, done: 1'b1, fail: 1'b0, cycles: 78};
    run_search('0, e, 0);

    // Abort during cycle 10 of the chain search: regions 0..2 committed.
    @(negedge clk);
    adj   = chain;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_flags", {61'd0, busy, done, fail}, 64'd0);
    check("abort_colors", {40'd0, colors}, 64'h4);
    check("abort_cur", {60'd0, cur_region}, 64'd3);
    repeat (3) @(negedge clk);
    check("abort_idle", {63'd0, busy}, 64'd0);

    // Chain with a stray start mid-search: alternating colors, 114 cycles.
    e = '{colors: 24'h444444, chk_colors: 1'b1, done: 1'b1, fail: 1'b0, cycles: 114};
    run_search(chain, e, 20);

    // K4 on regions 0..3: colors 0,1,2,3 then zeros, 88 cycles.
    e = '{colors: 24'h0000E4, chk_colors: 1'b1, done: 1'b1, fail: 1'b0, cycles: 88};
    run_search(k4, e, 0);

    // K5 cannot be 4-colored.
    e = '{colors: '0, chk_colors: 1'b0, done: 1'b0, fail: 1'b1, cycles: -1};
    run_search(k5, e, 0);

    // Restart from FAIL with an empty graph.
    e = '{colors: '0, chk_colors: 1'b1, done: 1'b1, fail: 1'b0, cycles: 78};
    run_search('0, e, 0);

    // Asynchronous reset mid-search, away from any clock edge.
    @(negedge clk);
    adj   = chain;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_colors", {40'd0, colors}, 64'd0);
    check("arst_cur", {60'd0, cur_region}, 64'd0);
    check("arst_flags", {61'd0, busy, done, fail}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {60'd0, busy, done, fail, 1'b0}, 64'd0);
    check("post_rst_cur", {60'd0, cur_region}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
